// File: rtl/tinyodin_obi_loader.sv
// tinyodin_obi_loader: OBI block-write master filling tinyODIN memories from a stream or a constant.
module tinyodin_obi_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_region_i,
    input  logic [12:0]       cmd_base_i,
    input  logic [5:0]        cmd_row_len_i,
    input  logic [5:0]        cmd_row_stride_i,
    input  logic [8:0]        cmd_num_rows_i,
    input  logic              cmd_fill_i,
    input  logic [DATA_W-1:0] cmd_fill_data_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              obi_req_o,
    output logic              obi_we_o,
    output logic [3:0]        obi_be_o,
    output logic [ADDR_W-1:0] obi_addr_o,
    output logic [DATA_W-1:0] obi_wdata_o,
    input  logic              obi_gnt_i,
    input  logic              obi_rvalid_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    typedef enum logic [2:0] {IDLE, CHECK, FETCH, REQ, RESP, DONE} state_t;
    state_t state_q;
    logic [1:0]        region_q;
    logic [12:0]       base_q, row_q, off_q;
    logic [5:0]        len_q, stride_q, c_q;
    logic [8:0]        rows_q, r_q;
    logic              fill_q;
    logic [DATA_W-1:0] fill_data_q, wdata_q;
    logic              cmd_ready_q, data_ready_q, req_q, busy_q, done_q, err_q;
    logic [22:0]       last, limit;
    logic              row_end, last_word;
    always_comb begin
        last      = 23'(base_q) + 23'(rows_q - 9'd1) * 23'(stride_q) + 23'(len_q) - 23'd1;
        limit     = region_q == 2'd0 ? 23'd64 : region_q == 2'd1 ? 23'd256 :
                    region_q == 2'd2 ? 23'd8192 : 23'd1;
        row_end   = c_q == len_q - 6'd1;
        last_word = row_end && r_q == rows_q - 9'd1;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            region_q     <= '0;
            base_q       <= '0;
            len_q        <= '0;
            stride_q     <= '0;
            rows_q       <= '0;
            fill_q       <= 1'b0;
            fill_data_q  <= '0;
            row_q        <= '0;
            off_q        <= '0;
            c_q          <= '0;
            r_q          <= '0;
            wdata_q      <= '0;
            cmd_ready_q  <= 1'b0;
            data_ready_q <= 1'b0;
            req_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid_i && cmd_ready_q) begin
                        region_q    <= cmd_region_i;
                        base_q      <= cmd_base_i;
                        len_q       <= cmd_row_len_i;
                        stride_q    <= cmd_row_stride_i;
                        rows_q      <= cmd_num_rows_i;
                        fill_q      <= cmd_fill_i;
                        fill_data_q <= cmd_fill_data_i;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= CHECK;
                    end
                end
                CHECK: begin
                    if (len_q == '0 || rows_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (last >= limit) begin
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        c_q          <= '0;
                        r_q          <= '0;
                        row_q        <= base_q;
                        off_q        <= base_q;
                        data_ready_q <= !fill_q;
                        state_q      <= FETCH;
                    end
                end
                FETCH: begin
                    if (fill_q) begin
                        wdata_q <= fill_data_q;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end else if (data_valid_i) begin
                        wdata_q      <= data_i;
                        data_ready_q <= 1'b0;
                        req_q        <= 1'b1;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    if (obi_gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (obi_rvalid_i) begin
                        // rows restart from the running row origin, so overlapping strides need no multiply
                        c_q   <= row_end ? 6'd0 : c_q + 6'd1;
                        r_q   <= row_end ? r_q + 9'd1 : r_q;
                        row_q <= row_end ? row_q + 13'(stride_q) : row_q;
                        off_q <= row_end ? row_q + 13'(stride_q) : off_q + 13'd1;
                        if (last_word) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            data_ready_q <= !fill_q;
                            state_q      <= FETCH;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign cmd_ready_o  = cmd_ready_q;
    assign data_ready_o = data_ready_q;
    assign obi_req_o    = req_q;
    assign obi_we_o     = req_q;
    assign obi_be_o     = {4{req_q}};
    assign obi_addr_o   = ADDR_W'({10'b0, region_q, 5'b0, off_q, 2'b00});
    assign obi_wdata_o  = wdata_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_tinyodin_obi_loader.sv
// tb_tinyodin_obi_loader: directed command table plus reset-abort sequence for the OBI loader.
module tb_tinyodin_obi_loader;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [1:0]  cmd_region_i = '0;
    logic [12:0] cmd_base_i = '0;
    logic [5:0]  cmd_row_len_i = '0;
    logic [5:0]  cmd_row_stride_i = '0;
    logic [8:0]  cmd_num_rows_i = '0;
    logic        cmd_fill_i = 1'b0;
    logic [31:0] cmd_fill_data_i = '0;
    logic        data_valid_i = 1'b0;
    logic        data_ready_o;
    logic [31:0] data_i = '0;
    logic        obi_req_o, obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_addr_o, obi_wdata_o;
    logic        obi_gnt_i = 1'b0;
    logic        obi_rvalid_i = 1'b0;
    logic        busy_o, done_o, err_o;

    tinyodin_obi_loader dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_region_i(cmd_region_i), .cmd_base_i(cmd_base_i),
        .cmd_row_len_i(cmd_row_len_i), .cmd_row_stride_i(cmd_row_stride_i),
        .cmd_num_rows_i(cmd_num_rows_i), .cmd_fill_i(cmd_fill_i),
        .cmd_fill_data_i(cmd_fill_data_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
        .obi_req_o(obi_req_o), .obi_we_o(obi_we_o), .obi_be_o(obi_be_o),
        .obi_addr_o(obi_addr_o), .obi_wdata_o(obi_wdata_o),
        .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  region;
        logic [12:0] base;
        logic [5:0]  len;
        logic [5:0]  stride;
        logic [8:0]  rows;
        logic        fill;
        logic [31:0] fdata;
        int          gd;
        int          rd;
        bit          tog;
        int          nw;
        bit          err;
        logic [31:0] first;
        logic [31:0] last;
    } vec_t;

    vec_t vecs[12];
    vec_t rs, post;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input vec_t v, input int n);
        int r, c;
        logic [12:0] off;
        r   = n / int'(v.len);
        c   = n % int'(v.len);
        off = 13'(int'(v.base) + r * int'(v.stride) + c);
        return {10'b0, v.region, 5'b0, off, 2'b00};
    endfunction

    function automatic logic [31:0] exp_data(input vec_t v, input int n);
        return v.fill ? v.fdata : 32'h5A00_0000 + 32'(n * 7);
    endfunction

    task automatic issue(input vec_t v);
        int t;
        cmd_region_i     = v.region;
        cmd_base_i       = v.base;
        cmd_row_len_i    = v.len;
        cmd_row_stride_i = v.stride;
        cmd_num_rows_i   = v.rows;
        cmd_fill_i       = v.fill;
        cmd_fill_data_i  = v.fdata;
        cmd_valid_i      = 1'b1;
        t = 0;
        while (!cmd_ready_o && t < 50) begin
            @(negedge CLK);
            t++;
        end
        chk("cmd_ready", 32'(cmd_ready_o), 32'd1);
        @(negedge CLK);
        cmd_valid_i = 1'b0;
    endtask

    task automatic run_cmd(input vec_t v);
        int cyc, widx, sidx, wait_g, rv_cnt, ecyc, budget;
        bit pend, in_req, got_d, got_e, saw_req;
        logic [31:0] ha, hd, fa, la;
        widx = 0; sidx = 0; wait_g = 0; rv_cnt = 0; ecyc = -1;
        pend = 0; in_req = 0; got_d = 0; got_e = 0; saw_req = 0;
        fa = '0; la = '0; ha = '0; hd = '0;
        budget = 60 + v.nw * (8 + v.gd + v.rd) * 2;
        issue(v);
        cyc = 1;
        while (cyc < budget) begin
            if (obi_req_o) saw_req = 1;
            if (done_o) got_d = 1;
            if (err_o) begin
                got_e = 1;
                ecyc  = cyc;
            end
            if (got_d || got_e) break;
            obi_rvalid_i = 1'b0;
            if (pend) begin
                if (rv_cnt == 0) begin
                    obi_rvalid_i = 1'b1;
                    pend = 0;
                end else rv_cnt--;
            end
            obi_gnt_i = 1'b0;
            if (obi_req_o) begin
                if (!in_req) begin
                    in_req = 1;
                    wait_g = 0;
                    ha = obi_addr_o;
                    hd = obi_wdata_o;
                    if (widx == 0) fa = obi_addr_o;
                    la = obi_addr_o;
                    if (pend) chk("outstanding", 32'd2, 32'd1);
                    chk("addr", obi_addr_o, exp_addr(v, widx));
                    chk("wdata", obi_wdata_o, exp_data(v, widx));
                    chk("we_be", {27'b0, obi_we_o, obi_be_o}, 32'h1F);
                end else if (obi_addr_o !== ha || obi_wdata_o !== hd) begin
                    chk("hold_addr", obi_addr_o, ha);
                    chk("hold_wdata", obi_wdata_o, hd);
                end
                if (wait_g >= v.gd) begin
                    obi_gnt_i = 1'b1;
                    pend   = 1;
                    rv_cnt = v.rd;
                    in_req = 0;
                    widx++;
                end else wait_g++;
            end
            data_valid_i = (sidx < v.nw) && (v.tog ? cyc[0] : 1'b1);
            data_i       = 32'h5A00_0000 + 32'(sidx * 7);
            if (data_valid_i && data_ready_o) sidx++;
            @(negedge CLK);
            cyc++;
        end
        obi_gnt_i = 1'b0;
        obi_rvalid_i = 1'b0;
        data_valid_i = 1'b0;
        chk("finished", 32'(got_d | got_e), 32'd1);
        chk("writes", 32'(widx), 32'(v.nw));
        chk("done", 32'(got_d), 32'(!v.err));
        chk("err", 32'(got_e), 32'(v.err));
        chk("stream_used", 32'(sidx), v.fill ? 32'd0 : 32'(v.nw));
        if (v.err) begin
            chk("err_cycle", 32'(ecyc), 32'd2);
            chk("req_on_err", 32'(saw_req), 32'd0);
        end
        if (v.nw > 0) begin
            chk("first_addr", fa, v.first);
            chk("last_addr", la, v.last);
        end
        chk("busy_end", 32'(busy_o), 32'd0);
        @(negedge CLK);
        chk("pulse_once", 32'(done_o | err_o), 32'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk(tag, {21'b0, cmd_ready_o, data_ready_o, obi_req_o, obi_we_o, obi_be_o,
                  busy_o, done_o, err_o}, 32'd0);
        chk({tag, "_addr"}, obi_addr_o, 32'd0);
        chk({tag, "_wdata"}, obi_wdata_o, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{2'd2, 13'd0,    6'd32, 6'd32, 9'd256, 1'b1, 32'h0,         0, 0, 1'b0, 8192, 1'b0, 32'h0020_0000, 32'h0020_7FFC};
        vecs[1]  = '{2'd2, 13'd18,   6'd13, 6'd32, 9'd144, 1'b0, 32'h0,         0, 0, 1'b0, 1872, 1'b0, 32'h0020_0048, 32'h0020_47F8};
        vecs[2]  = '{2'd1, 13'd250,  6'd8,  6'd1,  9'd1,   1'b1, 32'h11,        0, 0, 1'b0, 0,    1'b1, 32'h0,         32'h0};
        vecs[3]  = '{2'd3, 13'd0,    6'd1,  6'd0,  9'd1,   1'b1, 32'hFF00_0400, 0, 0, 1'b0, 1,    1'b0, 32'h0030_0000, 32'h0030_0000};
        vecs[4]  = '{2'd0, 13'd0,    6'd4,  6'd4,  9'd1,   1'b0, 32'h0,         3, 2, 1'b1, 4,    1'b0, 32'h0000_0000, 32'h0000_000C};
        vecs[5]  = '{2'd0, 13'd5,    6'd0,  6'd1,  9'd3,   1'b1, 32'h22,        0, 0, 1'b0, 0,    1'b0, 32'h0,         32'h0};
        vecs[6]  = '{2'd1, 13'd0,    6'd4,  6'd4,  9'd0,   1'b0, 32'h0,         0, 0, 1'b0, 0,    1'b0, 32'h0,         32'h0};
        vecs[7]  = '{2'd0, 13'd60,   6'd4,  6'd4,  9'd1,   1'b1, 32'hCAFE_0001, 1, 1, 1'b0, 4,    1'b0, 32'h0000_00F0, 32'h0000_00FC};
        vecs[8]  = '{2'd0, 13'd61,   6'd4,  6'd4,  9'd1,   1'b0, 32'h0,         0, 0, 1'b0, 0,    1'b1, 32'h0,         32'h0};
        vecs[9]  = '{2'd1, 13'd10,   6'd3,  6'd0,  9'd2,   1'b0, 32'h0,         0, 1, 1'b1, 6,    1'b0, 32'h0010_0028, 32'h0010_0030};
        vecs[10] = '{2'd3, 13'd1,    6'd1,  6'd0,  9'd1,   1'b1, 32'h33,        0, 0, 1'b0, 0,    1'b1, 32'h0,         32'h0};
        vecs[11] = '{2'd2, 13'd8191, 6'd1,  6'd5,  9'd1,   1'b0, 32'h0,         0, 0, 1'b0, 1,    1'b0, 32'h0020_7FFC, 32'h0020_7FFC};
        rs       = '{2'd2, 13'd100,  6'd4,  6'd4,  9'd1,   1'b1, 32'hDEAD_BEEF, 0, 0, 1'b0, 4,    1'b0, 32'h0,         32'h0};
        post     = '{2'd1, 13'd7,    6'd2,  6'd0,  9'd1,   1'b1, 32'h0000_1234, 0, 0, 1'b0, 2,    1'b0, 32'h0010_001C, 32'h0010_0020};

        repeat (3) @(negedge CLK);
        chk_reset_outs("reset_outs");
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 12; i++) run_cmd(vecs[i]);

        // abort a command while its request is pending, then restart cleanly
        issue(rs);
        for (int t = 0; t < 20 && !obi_req_o; t++) @(negedge CLK);
        chk("rst_req_seen", 32'(obi_req_o), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        chk_reset_outs("rst_abort");
        RST = 1'b0;
        @(negedge CLK);
        run_cmd(post);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
